// File: rtl/axi_defs.sv
// Shared AXI encodings and slave FSM state type for the SRAM-backed AXI slave.
package axi_defs;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    // WRAP is deliberately handled like INCR; only FIXED holds the address.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? a : a + 32'd4;
    endfunction
endpackage

// File: rtl/spram_be.sv
// Single-port synchronous word RAM with per-byte write enables and 1-cycle read latency.
module spram_be #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [3:0]        i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);
    logic [31:0] r_mem [0:(2**ADDR_W)-1];

    // Read data only updates on a pure read, so it stays stable across write beats and stalls.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
            if (i_we == 4'b0000) o_rdata <= r_mem[i_addr];
        end
    end
endmodule

// File: rtl/axi_sram_slave.sv
// AXI3/4-subset slave over a byte-writable word RAM; one transaction at a time,
// single-beat and FIXED/INCR bursts, optional extra latency before the first read beat.
module axi_sram_slave
    import axi_defs::*;
#(
    parameter int ADDR_W   = 12,
    parameter int RD_DELAY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam logic [3:0] DLY = 4'(RD_DELAY);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_id, w_id_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [7:0]  r_len, w_len_nxt;
    logic [1:0]  r_burst, w_burst_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_dly, w_dly_nxt;
    logic        r_rvalid, w_rvalid_nxt;
    logic        r_rlast, w_rlast_nxt;
    logic [3:0]  r_rid, w_rid_nxt;
    logic [1:0]  r_rresp, w_rresp_nxt;
    logic        r_wready, w_wready_nxt;
    logic        r_bvalid, w_bvalid_nxt;
    logic [3:0]  r_bid, w_bid_nxt;
    logic [1:0]  r_bresp, w_bresp_nxt;

    logic        w_ram_en;
    logic [3:0]  w_ram_we;
    logic [31:0] w_ram_q;
    logic        w_cnt_last;
    logic        w_unused;

    assign w_cnt_last = (r_cnt == r_len);
    assign w_unused   = ^{arsize, awsize, r_addr[31:ADDR_W+2], r_addr[1:0]};

    spram_be #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (r_addr[ADDR_W+1:2]),
        .i_wdata (wdata),
        .o_rdata (w_ram_q)
    );

    assign arready = (r_state == ST_IDLE);
    assign awready = (r_state == ST_IDLE) && !arvalid;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rid     = r_rid;
    assign rresp   = r_rresp;
    // RAM output is not resettable; gate it so rdata reads as zero whenever no beat is offered.
    assign rdata   = r_rvalid ? w_ram_q : 32'd0;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bid     = r_bid;
    assign bresp   = r_bresp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_burst  <= '0;
            r_cnt    <= '0;
            r_dly    <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rid    <= '0;
            r_rresp  <= '0;
            r_wready <= 1'b0;
            r_bvalid <= 1'b0;
            r_bid    <= '0;
            r_bresp  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_id     <= w_id_nxt;
            r_addr   <= w_addr_nxt;
            r_len    <= w_len_nxt;
            r_burst  <= w_burst_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dly    <= w_dly_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_rlast  <= w_rlast_nxt;
            r_rid    <= w_rid_nxt;
            r_rresp  <= w_rresp_nxt;
            r_wready <= w_wready_nxt;
            r_bvalid <= w_bvalid_nxt;
            r_bid    <= w_bid_nxt;
            r_bresp  <= w_bresp_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_id_nxt     = r_id;
        w_addr_nxt   = r_addr;
        w_len_nxt    = r_len;
        w_burst_nxt  = r_burst;
        w_cnt_nxt    = r_cnt;
        w_dly_nxt    = r_dly;
        w_rvalid_nxt = r_rvalid;
        w_rlast_nxt  = r_rlast;
        w_rid_nxt    = r_rid;
        w_rresp_nxt  = r_rresp;
        w_wready_nxt = r_wready;
        w_bvalid_nxt = r_bvalid;
        w_bid_nxt    = r_bid;
        w_bresp_nxt  = r_bresp;
        w_ram_en     = 1'b0;
        w_ram_we     = 4'b0000;

        case (r_state)
            ST_IDLE: begin
                if (arvalid) begin
                    w_id_nxt    = arid;
                    w_addr_nxt  = araddr;
                    w_len_nxt   = arlen;
                    w_burst_nxt = arburst;
                    w_cnt_nxt   = 8'd0;
                    w_dly_nxt   = DLY;
                    w_state_nxt = ST_RD_WAIT;
                end else if (awvalid) begin
                    w_id_nxt     = awid;
                    w_addr_nxt   = awaddr;
                    w_len_nxt    = awlen;
                    w_burst_nxt  = awburst;
                    w_cnt_nxt    = 8'd0;
                    w_wready_nxt = 1'b1;
                    w_state_nxt  = ST_WR_DATA;
                end
            end
            ST_RD_WAIT: begin
                if (r_dly != 4'd0) begin
                    w_dly_nxt = r_dly - 4'd1;
                end else begin
                    w_ram_en     = 1'b1;
                    w_rvalid_nxt = 1'b1;
                    w_rid_nxt    = r_id;
                    w_rresp_nxt  = RESP_OKAY;
                    w_rlast_nxt  = w_cnt_last;
                    w_state_nxt  = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (rready) begin
                    w_rvalid_nxt = 1'b0;
                    if (r_rlast) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        // Later beats skip the configured delay: one bubble per beat only.
                        w_cnt_nxt   = r_cnt + 8'd1;
                        w_addr_nxt  = next_addr(r_addr, r_burst);
                        w_dly_nxt   = 4'd0;
                        w_state_nxt = ST_RD_WAIT;
                    end
                end
            end
            ST_WR_DATA: begin
                if (wvalid && r_wready) begin
                    w_ram_en   = 1'b1;
                    w_ram_we   = wstrb;
                    w_cnt_nxt  = r_cnt + 8'd1;
                    w_addr_nxt = next_addr(r_addr, r_burst);
                    // Either wlast or the length count closes the burst; disagreement is a slave error.
                    if (wlast || w_cnt_last) begin
                        w_wready_nxt = 1'b0;
                        w_bvalid_nxt = 1'b1;
                        w_bid_nxt    = r_id;
                        w_bresp_nxt  = (wlast && w_cnt_last) ? RESP_OKAY : RESP_SLVERR;
                        w_state_nxt  = ST_WR_RESP;
                    end
                end
            end
            ST_WR_RESP: begin
                if (bready) begin
                    w_bvalid_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: table of single write/read vectors plus
// hand-written burst, tie, error and reset sequences, with R/B scoreboards.
module tb_axi_sram_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  arid = '0, awid = '0, rid, bid;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
    logic [7:0]  arlen = '0, awlen = '0;
    logic [2:0]  arsize = 3'd2, awsize = 3'd2;
    logic [1:0]  arburst = 2'b01, awburst = 2'b01, rresp, bresp;
    logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic        rready = 1'b0, bready = 1'b0;
    logic [3:0]  wstrb = '0;
    logic        arready, awready, rvalid, rlast, wready, bvalid;

    axi_sram_slave #(.ADDR_W(12), .RD_DELAY(0)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed { logic [3:0] id; logic [31:0] data; logic last; } rbeat_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; } bexp_t;
    typedef struct { logic [31:0] waddr; logic [31:0] wdata; logic [3:0] strb; logic [31:0] raddr; logic [31:0] exp; } vec_t;

    rbeat_t      rq[$];
    bexp_t       bq[$];
    logic [31:0] wd_q[$], re_q[$];
    logic [3:0]  ws_q[$];
    logic [31:0] mdl [0:4095];
    int          n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic tmo(input string nm);
        n_chk++;
        $display("FAIL timeout %s: event not seen, expected within bound", nm);
    endtask

    function automatic logic [11:0] widx(input logic [31:0] a);
        return a[13:2];
    endfunction

    // R scoreboard plus payload-stability check while stalled
    logic   hold_v = 1'b0;
    logic [38:0] held;
    rbeat_t r_e;
    always @(negedge clk) begin
        if (rst) hold_v = 1'b0;
        else if (rvalid) begin
            if (hold_v) chk("r_stable", {25'd0, rid, rdata, rlast, rresp}, {25'd0, held});
            if (rready) begin
                hold_v = 1'b0;
                if (rq.size() == 0) begin
                    n_chk++;
                    $display("FAIL r_unexpected: got beat data 0x%0h, expected no beat", rdata);
                end else begin
                    r_e = rq.pop_front();
                    chk("rdata", rdata, r_e.data);
                    chk("rid", rid, r_e.id);
                    chk("rlast", rlast, r_e.last);
                    chk("rresp", rresp, 2'b00);
                end
            end else begin
                held   = {rid, rdata, rlast, rresp};
                hold_v = 1'b1;
            end
        end
    end

    bexp_t b_e;
    always @(negedge clk) begin
        if (!rst && bvalid && bready) begin
            if (bq.size() == 0) begin
                n_chk++;
                $display("FAIL b_unexpected: got bid 0x%0h, expected no response", bid);
            end else begin
                b_e = bq.pop_front();
                chk("bid", bid, b_e.id);
                chk("bresp", bresp, b_e.resp);
            end
        end
    end

    task automatic set_wd(input int n, input logic [31:0] base, input logic [31:0] step);
        wd_q.delete(); ws_q.delete();
        for (int i = 0; i < n; i++) begin
            wd_q.push_back(base + step * 32'(i));
            ws_q.push_back(4'hF);
        end
    endtask

    task automatic exp_model(input logic [31:0] addr, input int len, input logic [1:0] burst);
        logic [31:0] a = addr;
        re_q.delete();
        for (int i = 0; i <= len; i++) begin
            re_q.push_back(mdl[widx(a)]);
            if (burst != 2'b00) a = a + 32'd4;
        end
    endtask

    task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int k;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (arready) break;
        end
        if (k == 50) begin tmo("arready"); arvalid = 1'b0; return; end
        @(posedge clk); #1 arvalid = 1'b0;
    endtask

    task automatic aw_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int k;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (awready) break;
        end
        if (k == 50) begin tmo("awready"); awvalid = 1'b0; return; end
        @(posedge clk); #1 awvalid = 1'b0;
    endtask

    // W beats from wd_q/ws_q, wlast on beat wl_at; burst ends at min(wl_at, len)
    task automatic wr_data(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input int wl_at, input logic [1:0] exp_resp, input int bstall);
        logic [31:0] a = addr;
        int last_b = (wl_at < len) ? wl_at : len;
        int k;
        for (int b = 0; b <= last_b; b++) begin
            wdata = wd_q[b]; wstrb = ws_q[b]; wlast = (b == wl_at); wvalid = 1'b1;
            for (k = 0; k < 40; k++) begin
                @(negedge clk);
                if (wready) break;
            end
            if (k == 40) begin tmo("wready"); wvalid = 1'b0; wlast = 1'b0; return; end
            for (int j = 0; j < 4; j++) if (wstrb[j]) mdl[widx(a)][8*j +: 8] = wdata[8*j +: 8];
            @(posedge clk); #1;
            if (burst != 2'b00) a = a + 32'd4;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bq.push_back('{id: id, resp: exp_resp});
        chk("b_valid_rise", bvalid, 1'b1);
        chk("w_ready_fall", wready, 1'b0);
        repeat (bstall) begin @(posedge clk); #1; end
        chk("b_held", bvalid, 1'b1);
        bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        chk("b_done", bvalid, 1'b0);
        chk("bq_empty", bq.size(), 0);
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input int wl_at, input logic [1:0] exp_resp, input int bstall);
        aw_hs(id, addr, len, burst);
        chk("w_ready_rise", wready, 1'b1);
        wr_data(id, addr, int'(len), burst, wl_at, exp_resp, bstall);
    endtask

    // Expected beats come from re_q; checks bubble and latency of every beat
    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input int stall_beat, input int stall_n);
        rbeat_t rb;
        int k;
        for (int b = 0; b <= int'(len); b++) begin
            rb.id = id; rb.data = re_q[b]; rb.last = (b == int'(len));
            rq.push_back(rb);
        end
        ar_hs(id, addr, len, burst);
        for (int b = 0; b <= int'(len); b++) begin
            chk("r_bubble", rvalid, 1'b0);
            for (k = 1; k <= 40; k++) begin
                @(posedge clk); #1;
                if (rvalid) break;
            end
            if (!rvalid) begin tmo("rvalid"); rq.delete(); return; end
            chk("r_latency", k, 1);
            if (b == stall_beat) begin
                repeat (stall_n) begin @(posedge clk); #1; end
                chk("r_stall_hold", rvalid, 1'b1);
            end
            rready = 1'b1;
            @(posedge clk); #1 rready = 1'b0;
        end
        chk("r_end_valid", rvalid, 1'b0);
        chk("r_end_idle", arready, 1'b1);
        chk("rq_empty", rq.size(), 0);
    endtask

    vec_t vt[7];
    int   k;

    initial begin
        vt[0] = '{32'h10,   32'hDEADBEEF, 4'hF,    32'h10,   32'hDEADBEEF};
        vt[1] = '{32'h10,   32'h11223344, 4'b0101, 32'h10,   32'hDE22BE44};
        vt[2] = '{32'h14,   32'hCAFEF00D, 4'hF,    32'h14,   32'hCAFEF00D};
        vt[3] = '{32'h14,   32'h00000000, 4'b1000, 32'h14,   32'h00FEF00D};
        vt[4] = '{32'h17,   32'h12345678, 4'b0010, 32'h14,   32'h00FE560D};
        vt[5] = '{32'h4010, 32'h55AA55AA, 4'hF,    32'h10,   32'h55AA55AA};
        vt[6] = '{32'h3FFC, 32'h0BADC0DE, 4'hF,    32'h3FFC, 32'h0BADC0DE};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rlast", rlast, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rid", rid, 4'd0);
        chk("rst_rresp", rresp, 2'd0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_bid", bid, 4'd0);
        chk("rst_bresp", bresp, 2'd0);
        chk("rst_wready", wready, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_arready", arready, 1'b1);
        chk("idle_awready", awready, 1'b1);

        for (int i = 0; i < 7; i++) begin
            wd_q.delete(); ws_q.delete();
            wd_q.push_back(vt[i].wdata); ws_q.push_back(vt[i].strb);
            wr_burst(4'(i), vt[i].waddr, 8'd0, 2'b01, 0, 2'b00, i % 2);
            re_q.delete(); re_q.push_back(vt[i].exp);
            rd_burst(4'(i + 1), vt[i].raddr, 8'd0, 2'b01, -1, 0);
        end

        // INCR burst with a 3-cycle stall on the second beat
        set_wd(4, 32'd1, 32'd1);
        wr_burst(4'd3, 32'h20, 8'd3, 2'b01, 3, 2'b00, 0);
        re_q.delete();
        for (int i = 1; i <= 4; i++) re_q.push_back(32'(i));
        rd_burst(4'd9, 32'h20, 8'd3, 2'b01, 1, 3);

        // FIXED write lands every beat on one word; WRAP behaves as INCR
        set_wd(3, 32'hC0DE0000, 32'd1);
        wr_burst(4'd4, 32'h240, 8'd2, 2'b00, 2, 2'b00, 0);
        re_q.delete(); re_q.push_back(32'hC0DE0002); re_q.push_back(32'hC0DE0002);
        rd_burst(4'd5, 32'h240, 8'd1, 2'b00, -1, 0);
        set_wd(2, 32'hA5A50000, 32'd1);
        wr_burst(4'd6, 32'h200, 8'd1, 2'b10, 1, 2'b00, 1);
        re_q.delete(); re_q.push_back(32'hA5A50000); re_q.push_back(32'hA5A50001);
        rd_burst(4'd7, 32'h200, 8'd1, 2'b01, -1, 0);

        // Early wlast and missing wlast both give SLVERR with accepted beats kept
        set_wd(4, 32'hAAAA0000, 32'd1);
        wr_burst(4'd10, 32'h80, 8'd3, 2'b01, 3, 2'b00, 0);
        set_wd(4, 32'hBBBB0000, 32'd1);
        wr_burst(4'd11, 32'h80, 8'd3, 2'b01, 1, 2'b10, 0);
        re_q.delete();
        re_q.push_back(32'hBBBB0000); re_q.push_back(32'hBBBB0001);
        re_q.push_back(32'hAAAA0002); re_q.push_back(32'hAAAA0003);
        rd_burst(4'd12, 32'h80, 8'd3, 2'b01, -1, 0);
        set_wd(2, 32'hCCCC0000, 32'd1);
        wr_burst(4'd13, 32'h90, 8'd1, 2'b01, 9, 2'b10, 0);
        re_q.delete(); re_q.push_back(32'hCCCC0000); re_q.push_back(32'hCCCC0001);
        rd_burst(4'd14, 32'h90, 8'd1, 2'b01, -1, 0);

        // Burst crossing the top of memory wraps to word 0
        set_wd(4, 32'h77000000, 32'h11);
        wr_burst(4'd15, 32'h3FF8, 8'd3, 2'b01, 3, 2'b00, 0);
        re_q.delete(); re_q.push_back(32'h77000022);
        rd_burst(4'd1, 32'h0, 8'd0, 2'b01, -1, 0);
        exp_model(32'h3FF8, 3, 2'b01);
        rd_burst(4'd2, 32'h3FF8, 8'd3, 2'b01, -1, 0);

        // 256-beat bursts
        set_wd(256, 32'h10000000, 32'h00010003);
        wr_burst(4'd8, 32'h400, 8'd255, 2'b01, 255, 2'b00, 0);
        exp_model(32'h400, 255, 2'b01);
        rd_burst(4'd8, 32'h400, 8'd255, 2'b01, 200, 2);

        // AR/AW tie: read wins, write accepted right after R completes
        arid = 4'd7; araddr = 32'h10; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
        awid = 4'd8; awaddr = 32'h300; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
        r_e.id = 4'd7; r_e.data = 32'h55AA55AA; r_e.last = 1'b1;
        rq.push_back(r_e);
        @(negedge clk);
        chk("tie_awready", awready, 1'b0);
        chk("tie_arready", arready, 1'b1);
        @(posedge clk); #1 arvalid = 1'b0;
        chk("tie_aw_busy", awready, 1'b0);
        for (k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (rvalid) break;
        end
        if (!rvalid) tmo("tie_rvalid");
        chk("tie_r_latency", k, 1);
        rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
        chk("tie_aw_after_r", awready, 1'b1);
        @(posedge clk); #1 awvalid = 1'b0;
        chk("tie_wready", wready, 1'b1);
        wd_q.delete(); ws_q.delete(); wd_q.push_back(32'hFACEFACE); ws_q.push_back(4'hF);
        wr_data(4'd8, 32'h300, 0, 2'b01, 0, 2'b00, 0);
        re_q.delete(); re_q.push_back(32'hFACEFACE);
        rd_burst(4'd3, 32'h300, 8'd0, 2'b01, -1, 0);

        // Async reset during the second beat of a 4-beat read
        r_e.id = 4'd5; r_e.data = 32'd1; r_e.last = 1'b0;
        rq.push_back(r_e);
        ar_hs(4'd5, 32'h20, 8'd3, 2'b01);
        for (k = 1; k <= 40; k++) begin @(posedge clk); #1; if (rvalid) break; end
        rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
        for (k = 1; k <= 40; k++) begin @(posedge clk); #1; if (rvalid) break; end
        chk("rstmid_beat2_up", rvalid, 1'b1);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("rstmid_rvalid", rvalid, 1'b0);
        chk("rstmid_rdata", rdata, 32'd0);
        chk("rstmid_rid", rid, 4'd0);
        chk("rstmid_rlast", rlast, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rstmid_arready", arready, 1'b1);
        chk("rstmid_rq", rq.size(), 0);
        re_q.delete();
        for (int i = 1; i <= 4; i++) re_q.push_back(32'(i));
        rd_burst(4'd6, 32'h20, 8'd3, 2'b01, -1, 0);

        chk("final_rq", rq.size(), 0);
        chk("final_bq", bq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
        $fatal(1);
    end
endmodule
